clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl_if.sv | 33 +++
 rtl/clk_gate_ctrl.sv | 109 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_ctrl_if.sv
// Clock-gate controller bus: wake/activity inputs, gate feedback,
// and per-domain enable/ready/error outputs.
interface clk_gate_ctrl_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   auto_en_i;
    logic [NUM_DOMAINS-1:0] req_i;
    logic [NUM_DOMAINS-1:0] busy_i;
    logic [NUM_DOMAINS-1:0] gate_fb_i;
    logic [NUM_DOMAINS-1:0] clk_en_o;
    logic [NUM_DOMAINS-1:0] ready_o;
    logic [NUM_DOMAINS-1:0] err_o;

    modport master (
        output auto_en_i,
        output req_i,
        output busy_i,
        output gate_fb_i,
        input  clk_en_o,
        input  ready_o,
        input  err_o
    );

    modport slave (
        input  auto_en_i,
        input  req_i,
        input  busy_i,
        input  gate_fb_i,
        output clk_en_o,
        output ready_o,
        output err_o
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gate sequencer: OFF/WAKE/ON/DRAIN with idle
// detection, gate feedback handshake and sticky timeout flag.
module clk_gate_ctrl #(
    parameter int NUM_DOMAINS  = 4,
    parameter int IDLE_CYCLES  = 16,
    parameter int WAKE_TIMEOUT = 8
) (
    input  logic         clk_i,
    input  logic         srst_i,
    clk_gate_ctrl_if.slave bus
);
    localparam int IW = $clog2(IDLE_CYCLES);
    localparam int HW = $clog2(WAKE_TIMEOUT + 1);

    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);
    localparam logic [HW-1:0] HS_MAX   = HW'(WAKE_TIMEOUT);
    localparam logic [HW-1:0] HS_LAST  = HW'(WAKE_TIMEOUT - 1);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_WAKE  = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [NUM_DOMAINS-1:0] en_v;
    logic [NUM_DOMAINS-1:0] rdy_v;
    logic [NUM_DOMAINS-1:0] err_v;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        logic [1:0]    state_q, state_d;
        logic [IW-1:0] idle_q, idle_d;
        logic [HW-1:0] hs_q, hs_d;
        logic          err_q, err_d;
        logic          en_q, rdy_q;
        logic          active, fb, hs_stay;

        assign active = bus.req_i[i] | bus.busy_i[i] | ~bus.auto_en_i;
        assign fb     = bus.gate_fb_i[i];

        always_comb begin
            state_d = state_q;
            idle_d  = idle_q;
            unique case (state_q)
                ST_OFF: begin
                    if (active) state_d = ST_WAKE;
                end
                ST_WAKE: begin
                    if (fb) begin
                        state_d = ST_ON;
                        idle_d  = '0;
                    end
                end
                ST_ON: begin
                    if (active) begin
                        idle_d = '0;
                    end else if (idle_q == IDLE_MAX) begin
                        state_d = ST_DRAIN;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!fb) state_d = ST_OFF;
                end
                default: state_d = ST_OFF;
            endcase
        end

        // Handshake counter runs only while waiting on feedback, so it
        // reads zero on every entry into WAKE or DRAIN.
        assign hs_stay = ((state_q == ST_WAKE) && !fb) ||
                         ((state_q == ST_DRAIN) && fb);

        always_comb begin
            hs_d  = '0;
            err_d = err_q;
            if (hs_stay) begin
                hs_d = (hs_q == HS_MAX) ? hs_q : hs_q + 1'b1;
                if (hs_q == HS_LAST) err_d = 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                state_q <= ST_OFF;
                idle_q  <= '0;
                hs_q    <= '0;
                err_q   <= 1'b0;
                en_q    <= 1'b0;
                rdy_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                idle_q  <= idle_d;
                hs_q    <= hs_d;
                err_q   <= err_d;
                en_q    <= (state_d == ST_WAKE) || (state_d == ST_ON);
                rdy_q   <= (state_d == ST_ON);
            end
        end

        assign en_v[i]  = en_q;
        assign rdy_v[i] = rdy_q;
        assign err_v[i] = err_q;
    end

    assign bus.clk_en_o = en_v;
    assign bus.ready_o  = rdy_v;
    assign bus.err_o    = err_v;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed scenarios plus random traffic
// compared against a behavioural per-domain model.
module tb_clk_gate_ctrl;
    localparam int ND = 4;
    localparam int IC = 8;
    localparam int WT = 8;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    clk_gate_ctrl_if #(.NUM_DOMAINS(ND)) bus ();

    logic [ND-1:0] fb_dly = '0;
    logic [ND-1:0] fb_mask;
    logic [ND-1:0] fb_val;
    always @(posedge clk) fb_dly <= bus.clk_en_o;
    assign bus.gate_fb_i = (fb_dly & ~fb_mask) | (fb_val & fb_mask);

    clk_gate_ctrl #(
        .NUM_DOMAINS (ND),
        .IDLE_CYCLES (IC),
        .WAKE_TIMEOUT(WT)
    ) dut (
        .clk_i (clk),
        .srst_i(srst),
        .bus   (bus)
    );

    typedef enum int {M_OFF, M_WAKE, M_ON, M_DRAIN} mstate_e;
    mstate_e       ms[ND];
    int            idle_run[ND];
    int            wait_n[ND];
    logic [ND-1:0] m_err = '0;
    int            total = 0;
    int            bad = 0;

    task automatic model_step();
        for (int i = 0; i < ND; i++) begin
            bit act;
            act = bus.req_i[i] | bus.busy_i[i] | ~bus.auto_en_i;
            if (srst) begin
                ms[i] = M_OFF;
                idle_run[i] = 0;
                wait_n[i] = 0;
                m_err[i] = 1'b0;
            end else begin
                case (ms[i])
                    M_OFF: if (act) begin
                        ms[i] = M_WAKE;
                        wait_n[i] = 0;
                    end
                    M_WAKE: if (bus.gate_fb_i[i]) begin
                        ms[i] = M_ON;
                        idle_run[i] = 0;
                    end else begin
                        wait_n[i]++;
                        if (wait_n[i] == WT) m_err[i] = 1'b1;
                    end
                    M_ON: if (act) begin
                        idle_run[i] = 0;
                    end else begin
                        idle_run[i]++;
                        if (idle_run[i] == IC) begin
                            ms[i] = M_DRAIN;
                            wait_n[i] = 0;
                        end
                    end
                    default: if (!bus.gate_fb_i[i]) begin
                        ms[i] = M_OFF;
                    end else begin
                        wait_n[i]++;
                        if (wait_n[i] == WT) m_err[i] = 1'b1;
                    end
                endcase
            end
        end
    endtask

    function automatic logic [3*ND-1:0] model_out();
        logic [ND-1:0] e, r;
        for (int i = 0; i < ND; i++) begin
            e[i] = (ms[i] == M_WAKE) || (ms[i] == M_ON);
            r[i] = (ms[i] == M_ON);
        end
        return {e, r, m_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        bus.auto_en_i = 1'b1;
        bus.req_i = '0;
        bus.busy_i = '0;
        fb_mask = '0;
        fb_val = '0;
        tick();
        tick();
        srst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3*ND-1:0] o;
        srst = 1'b1;
        fb_mask = '0;
        fb_val = '0;
        for (int k = 0; k < 3; k++) begin
            bus.auto_en_i = 1'($urandom_range(0, 1));
            bus.req_i = ND'($urandom);
            bus.busy_i = ND'($urandom);
            tick();
            o = {bus.clk_en_o, bus.ready_o, bus.err_o};
            total++;
            if (o !== '0) begin
                bad++;
                $display("FAIL reset_hold: got %h want 0", o);
            end
        end
        bus.auto_en_i = 1'b1;
        bus.req_i = '0;
        bus.busy_i = '0;
        srst = 1'b0;
        tick();
        o = {bus.clk_en_o, bus.ready_o, bus.err_o};
        total++;
        if (o !== '0) begin
            bad++;
            $display("FAIL reset_idle: got %h want 0", o);
        end
    endtask

    task automatic test_req_pulse();
        logic [1:0] o, e;
        do_reset();
        tick();
        bus.req_i = 4'b0001;
        tick();
        bus.req_i = '0;
        total++;
        if (bus.clk_en_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL req_en: got %b want 1", bus.clk_en_o[0]);
        end
        tick();
        total++;
        if (bus.ready_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL req_rdy_early: got %b want 0", bus.ready_o[0]);
        end
        tick();
        total++;
        if (bus.ready_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL req_rdy: got %b want 1", bus.ready_o[0]);
        end
        for (int k = 1; k <= IC; k++) begin
            tick();
            e = (k < IC) ? 2'b11 : 2'b00;
            o = {bus.clk_en_o[0], bus.ready_o[0]};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL req_idle k=%0d: got %b want %b", k, o, e);
            end
        end
    endtask

    task automatic test_busy_hold();
        int n;
        do_reset();
        bus.busy_i = 4'b0010;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k >= 3) begin
                total++;
                if (bus.ready_o[1] !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_rdy k=%0d: got %b want 1",
                             k, bus.ready_o[1]);
                end
            end
        end
        bus.busy_i = '0;
        n = 1;
        do begin
            tick();
            n++;
        end while (bus.clk_en_o[1] === 1'b1 && n < 40);
        total++;
        if (n != IC + 1 || bus.ready_o[1] !== 1'b0) begin
            bad++;
            $display("FAIL busy_gate: got %0d cycles rdy=%b want %0d rdy=0",
                     n, bus.ready_o[1], IC + 1);
        end
    endtask

    task automatic test_auto_off();
        int n;
        srst = 1'b1;
        bus.auto_en_i = 1'b0;
        bus.req_i = '0;
        bus.busy_i = '0;
        fb_mask = '0;
        fb_val = '0;
        tick();
        tick();
        srst = 1'b0;
        tick();
        total++;
        if (bus.clk_en_o !== 4'hF) begin
            bad++;
            $display("FAIL auto_en: got %h want f", bus.clk_en_o);
        end
        tick();
        tick();
        total++;
        if (bus.ready_o !== 4'hF) begin
            bad++;
            $display("FAIL auto_rdy: got %h want f", bus.ready_o);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if ({bus.clk_en_o, bus.ready_o} !== 8'hFF) begin
                bad++;
                $display("FAIL auto_hold: got %h want ff",
                         {bus.clk_en_o, bus.ready_o});
            end
        end
        bus.auto_en_i = 1'b1;
        n = 1;
        do begin
            tick();
            n++;
        end while (bus.clk_en_o === 4'hF && n < 40);
        total++;
        if (n != IC + 1 || bus.clk_en_o !== 4'h0) begin
            bad++;
            $display("FAIL auto_gate: got %0d cycles en=%h want %0d en=0",
                     n, bus.clk_en_o, IC + 1);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] o, e;
        do_reset();
        fb_mask = 4'b0100;
        fb_val = '0;
        bus.req_i = 4'b0100;
        tick();
        bus.req_i = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick();
            e = {1'b1, 1'b0, (k >= WT + 1)};
            o = {bus.clk_en_o[2], bus.ready_o[2], bus.err_o[2]};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL tmo_wake k=%0d: got %b want %b", k, o, e);
            end
        end
        fb_mask = '0;
        tick();
        total++;
        if ({bus.ready_o[2], bus.err_o[2]} !== 2'b11) begin
            bad++;
            $display("FAIL tmo_on: got %b want 11",
                     {bus.ready_o[2], bus.err_o[2]});
        end
        repeat (20) tick();
        total++;
        if (bus.err_o !== 4'b0100) begin
            bad++;
            $display("FAIL tmo_sticky: got %b want 0100", bus.err_o);
        end
        srst = 1'b1;
        tick();
        srst = 1'b0;
        total++;
        if (bus.err_o !== 4'b0000) begin
            bad++;
            $display("FAIL tmo_clear: got %b want 0000", bus.err_o);
        end
    endtask

    task automatic test_drain_req();
        int n;
        do_reset();
        bus.req_i = 4'b1000;
        tick();
        bus.req_i = '0;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.clk_en_o[3] === 1'b1 && n < 30);
        total++;
        if (n >= 30) begin
            bad++;
            $display("FAIL drain_reach: got timeout want gating");
        end
        fb_mask = 4'b1000;
        fb_val = 4'b1000;
        bus.req_i = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (bus.clk_en_o[3] !== 1'b0) begin
                bad++;
                $display("FAIL drain_hold k=%0d: got %b want 0",
                         k, bus.clk_en_o[3]);
            end
        end
        fb_mask = '0;
        tick();
        total++;
        if (bus.clk_en_o[3] !== 1'b0) begin
            bad++;
            $display("FAIL drain_off: got %b want 0", bus.clk_en_o[3]);
        end
        tick();
        total++;
        if ({bus.clk_en_o[3], bus.err_o[3]} !== 2'b10) begin
            bad++;
            $display("FAIL drain_rewake: got %b want 10",
                     {bus.clk_en_o[3], bus.err_o[3]});
        end
        bus.req_i = '0;
    endtask

    task automatic test_reset_mid_wake();
        logic [3*ND-1:0] o;
        do_reset();
        fb_mask = 4'b0001;
        fb_val = '0;
        bus.req_i = 4'b0001;
        tick();
        bus.req_i = '0;
        repeat (9) tick();
        total++;
        if ({bus.clk_en_o[0], bus.err_o[0]} !== 2'b11) begin
            bad++;
            $display("FAIL mid_pre: got %b want 11",
                     {bus.clk_en_o[0], bus.err_o[0]});
        end
        srst = 1'b1;
        tick();
        o = {bus.clk_en_o, bus.ready_o, bus.err_o};
        total++;
        if (o !== '0) begin
            bad++;
            $display("FAIL mid_reset: got %h want 0", o);
        end
        srst = 1'b0;
        fb_mask = '0;
    endtask

    task automatic test_random();
        logic [3*ND-1:0] o, e;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < ND; i++) begin
                bus.req_i[i] = ($urandom_range(0, 7) == 0);
                bus.busy_i[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 39) == 0) fb_mask[i] = ~fb_mask[i];
                if ($urandom_range(0, 3) == 0) fb_val[i] = ~fb_val[i];
            end
            if ($urandom_range(0, 49) == 0) bus.auto_en_i = ~bus.auto_en_i;
            srst = ($urandom_range(0, 499) == 0);
            tick();
            o = {bus.clk_en_o, bus.ready_o, bus.err_o};
            e = model_out();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rand k=%0d: got %h want %h", k, o, e);
            end
        end
        srst = 1'b0;
    endtask

    initial begin
        srst = 1'b1;
        bus.auto_en_i = 1'b1;
        bus.req_i = '0;
        bus.busy_i = '0;
        fb_mask = '0;
        fb_val = '0;
        test_reset();
        test_req_pulse();
        test_busy_hold();
        test_auto_off();
        test_timeout();
        test_drain_req();
        test_reset_mid_wake();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule
